// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and counter sizing helper.
package mdu_pkg;

    // op encodings as presented on the op input
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Width of the iteration counter that must reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shared shift-add / restoring shift-subtract datapath. A 2*WIDTH
// accumulator holds {partial product, multiplier} for multiply and
// {partial remainder, dividend/quotient} for divide. The mode is captured
// at load and held for the whole iteration.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] div_next;

    // One iteration step for both modes; the registered mode picks the result.
    // NOTE: every always_comb output gets a value on every path (here by
    // unconditional assignment) so no latch can be inferred.
    always_comb begin
        // multiply: add multiplicand into upper half when multiplier LSB is set,
        // then shift the whole accumulator (carry included) right by one
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        // divide: shift next dividend bit into the remainder, subtract divisor
        // if it fits, and shift the quotient bit in at the bottom
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, opnd_q};
        rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;
        div_next  = rem_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    // Accumulator, operand and mode registers: load operands, then iterate.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else if (load) begin
            acc_q  <= {{WIDTH{1'b0}}, (div_mode ? op_a : op_b)};
            opnd_q <= div_mode ? op_b : op_a;
            div_q  <= div_mode;
        end else if (step) begin
            acc_q  <= div_q ? div_next : mul_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Takes WIDTH+2 cycles from accepted start to readable result; MTHI/MTLO
// write in one cycle. Optional macro MDU_MADD_EN enables MADD/MSUB
// (signed multiply-accumulate into {HI,LO}); without it ops 110/111 are
// ignored.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic               neg_q;     // negate product / quotient
    logic               neg_r;     // negate remainder
    logic               div0;      // divisor was zero

    logic               iter_op;
    logic               signed_op;
    logic               div_op;
    logic               load;
    logic               last_step;
    logic               write_back;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] result;

    // Decode the incoming request and form operand magnitudes.
    always_comb begin
        iter_op = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: iter_op = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB:                   iter_op = 1'b1;
`endif
            default:                            iter_op = 1'b0;
        endcase
        signed_op = (op == OP_MULT) || (op == OP_DIV) ||
                    (op == OP_MADD) || (op == OP_MSUB);
        div_op    = (op == OP_DIV) || (op == OP_DIVU);
        mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    assign load       = (state == IDLE) && start && iter_op;
    assign last_step  = (cnt == CW'(WIDTH - 1));
    assign write_back = (state == FIX) && !cancel;
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: IDLE -> CALC for WIDTH steps -> FIX -> IDLE; cancel aborts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CALC;
            CALC:    if (cancel)         state_next = IDLE;
                     else if (last_step) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Iteration counter and per-operation flags captured at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= OP_MULT;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            op_q  <= op;
            neg_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= signed_op && div_op && a[WIDTH-1];
            div0  <= div_op && (b == '0);
        end else if (state == CALC) begin
            cnt   <= cnt + 1'b1;
        end
    end

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (state == CALC),
        .div_mode (div_op),
        .op_a     (mag_a),
        .op_b     (mag_b),
        .acc      (acc)
    );

    // Sign correction and result selection applied in FIX.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (div0) quot = '1;
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) result = {rem, quot};
        else                                       result = prod;
`ifdef MDU_MADD_EN
        // accumulate wraps modulo 2^(2*WIDTH)
        if (op_q == OP_MADD)      result = {hi, lo} + prod;
        else if (op_q == OP_MSUB) result = {hi, lo} - prod;
`endif
    end

    // HI/LO registers and done pulse: MTHI/MTLO from IDLE, results from FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= write_back;
            if (write_back) begin
                hi <= result[2*WIDTH-1:WIDTH];
                lo <= result[WIDTH-1:0];
            end else if ((state == IDLE) && start) begin
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32).
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Issue one op (now=1: drive in the current negedge slot) and wait for done.
    // lat = cycle of done (-1 on timeout), busy_n = cycles with busy high.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input bit now, output int lat, output int busy_n);
        if (!now) @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        lat = -1; busy_n = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin lat = n; break; end
        end
    endtask

    // Single-cycle register move.
    task automatic move(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; a = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %h want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    endtask

    task automatic test_mult();
        int lat, bn;
        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, lat, bn);
        checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", lat); end
        checks++; if (bn !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bn); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, lat, bn);
        checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL multu_hi got %h want 00000002", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", lo); end
        run_op(OP_MULT, 32'h80000000, 32'h80000000, 1'b0, lat, bn);
        checks++; if ({hi, lo} !== 64'h4000000000000000) begin errors++; $display("FAIL mult_min_min got %h want 4000000000000000", {hi, lo}); end
    endtask

    task automatic test_div();
        int lat, bn;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bn);
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bn);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_min_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_min_hi got %h want 0", hi); end
        run_op(OP_DIVU, 32'd7, 32'd0, 1'b0, lat, bn);
        checks++; if (hi !== 32'd7) begin errors++; $display("FAIL divu0_hi got %h want 7", hi); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo got %h want ffffffff", lo); end
        checks++; if (bn !== 33) begin errors++; $display("FAIL divu0_busy_cycles got %0d want 33", bn); end
        run_op(OP_DIV, 32'hFFFFFFF6, 32'd0, 1'b0, lat, bn);
        checks++; if ({hi, lo} !== 64'hFFFFFFF6FFFFFFFF) begin errors++; $display("FAIL div0_signed got %h want fffffff6ffffffff", {hi, lo}); end
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd16, 1'b0, lat, bn);
        checks++; if ({hi, lo} !== 64'h0000000F0FFFFFFF) begin errors++; $display("FAIL divu_big got %h want 0000000f0fffffff", {hi, lo}); end
    endtask

    task automatic test_cancel();
        logic [31:0] lo_before;
        bit          seen_done;
        bit          busy_late;
        move(OP_MTHI, 32'h12345678);
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        lo_before = lo;
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd7;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 5) cancel = 1'b1;
        end
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy_c6 got %h want 0", busy); end
        seen_done = (done === 1'b1);
        busy_late = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (busy) busy_late = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL cancel_done got %h want 0", seen_done); end
        checks++; if (busy_late !== 1'b0) begin errors++; $display("FAIL cancel_busy_after got %h want 0", busy_late); end
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL cancel_hi got %h want 12345678", hi); end
        checks++; if (lo !== lo_before) begin errors++; $display("FAIL cancel_lo got %h want %h", lo, lo_before); end
    endtask

    task automatic test_reset_mid_op();
        int lat, bn;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 10) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %h want 0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midreset_hilo got %h want 0", {hi, lo}); end
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, lat, bn);
        checks++; if (lat !== 34) begin errors++; $display("FAIL midreset_latency got %0d want 34", lat); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL midreset_lo got %h want e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL midreset_hi got %h want 2", hi); end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, lat, bn);
        checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL b2b_first got %h want 2a", {hi, lo}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got %h want 0", busy); end
        run_op(OP_DIV, 32'd100, 32'hFFFFFFF9, 1'b1, lat, bn);
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
        checks++; if (lo !== 32'hFFFFFFF2) begin errors++; $display("FAIL b2b_lo got %h want fffffff2", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi got %h want 2", hi); end
    endtask

    task automatic test_madd();
`ifdef MDU_MADD_EN
        int lat, bn;
        move(OP_MTHI, 32'h0);
        move(OP_MTLO, 32'hFFFFFFFF);
        run_op(OP_MADD, 32'd1, 32'd1, 1'b0, lat, bn);
        checks++; if (lat !== 34) begin errors++; $display("FAIL madd_latency got %0d want 34", lat); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL madd_hi got %h want 1", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL madd_lo got %h want 0", lo); end
        run_op(OP_MSUB, 32'd1, 32'd1, 1'b0, lat, bn);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL msub_hi got %h want 0", hi); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL msub_lo got %h want ffffffff", lo); end
`else
        bit saw_busy;
        move(OP_MTHI, 32'h0);
        move(OP_MTLO, 32'hFFFFFFFF);
        saw_busy = 1'b0;
        @(negedge clk);
        start = 1'b1; op = OP_MADD; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        if (busy) saw_busy = 1'b1;
        @(negedge clk);
        start = 1'b1; op = OP_MSUB;
        @(negedge clk);
        start = 1'b0;
        if (busy) saw_busy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL madd_off_busy got %h want 0", saw_busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL madd_off_hi got %h want 0", hi); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL madd_off_lo got %h want ffffffff", lo); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_cancel();
        test_reset_mid_op();
        test_back_to_back();
        test_madd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with architectural HI/LO registers, the multi-cycle successor to the single-cycle multiplier, divider and HiLo path in the CPU top. It executes MULT/MULTU/DIV/DIVU (plus MTHI/MTLO and optional MADD/MSUB) over WIDTH cycles using one shared shift-add/shift-subtract datapath. It exposes a busy/done handshake so the control unit can stall `mfhi`/`mflo` and new MDU ops, and a cancel input so CP0 exceptions can abort an in-flight operation.

## Interface
- WIDTH, 32, operand/HI/LO width; must be ≥ 4 and even.
- clk  in  1  single clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  request; sampled only when busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- cancel  in  1  abort the in-flight operation; HI/LO are not written.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, HI/LO were just updated by an iterative op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op ∈ {MTHI, MTLO}:
  - Write a into HI or LO at the edge.
  - No busy, no done.
- IDLE, start=1, iterative op:
  - Latch magnitudes (signed ops) or raw values (unsigned), record sign flags.
  - Clear the counter, go to CALC.
- CALC performs one bit per cycle for WIDTH cycles:
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Leaves CALC when the counter reaches WIDTH−1.
- FIX:
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO, return to IDLE.
- Results:
  - Multiply: HI = upper half, LO = lower half.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: HI = a, LO = all ones (both signed and unsigned), no trap.
- Signed MIN / −1: LO = MIN, HI = 0.
- start while busy=1 is ignored; the caller must hold it.
- cancel=1 in CALC or FIX: go to IDLE at the edge, no HI/LO write, no done. cancel in IDLE has no effect.
- reset at any time: IDLE, HI = LO = 0, busy = done = 0. Reset takes priority over cancel.

## Timing
- Outputs after reset: busy 0, done 0, hi 0, lo 0.
- start sampled in cycle 0:
  - busy = 1 in cycles 1 … WIDTH+1 (CALC for WIDTH cycles, FIX for 1).
  - New hi/lo and done = 1 in cycle WIDTH+2, with busy = 0.
- Latency is WIDTH+2 cycles from start to readable result, for every op and operand value. There is no early termination.
- A new start is accepted in the done cycle.
- MTHI/MTLO: result visible in cycle 1.

## Configuration
- MDU_MADD_EN defined:
  - op 110 computes {HI,LO} ← {HI,LO} + signed(a·b).
  - op 111 computes {HI,LO} ← {HI,LO} − signed(a·b).
  - The 2·WIDTH add/sub happens in FIX; latency is unchanged, and the sum wraps modulo 2^(2·WIDTH).
- MDU_MADD_EN undefined: op 110/111 with start=1 is ignored; no busy, no write.

## Structure
- Package mdu_pkg holds:
  - the op encoding constants;
  - the state enum (IDLE/CALC/FIX);
  - the counter width function (clog2(WIDTH)).
- Sub-module mdu_iter_core: the shared accumulator/shift register and add/subtract step, controlled by a mul/div select.
- The top holds the FSM, sign handling, HI/LO and the handshake.

## Test plan (WIDTH=32)
- MULT a=0xFFFFFFFE, b=3 → done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7, b=0 → hi=7, lo=0xFFFFFFFF; busy lasts exactly 33 cycles.
- MTHI 0x12345678 followed by a MULT with cancel asserted in cycle 5 → busy drops in cycle 6; hi=0x12345678 and lo are unchanged; no done pulse.
- reset asserted in cycle 10 of a DIVU, then start DIVU a=100, b=7 in the same cycle reset deasserts → first op is discarded; result lo=14, hi=2.
- MDU_MADD_EN: MTLO 0xFFFFFFFF, then MADD a=1, b=1 → hi=1, lo=0. Then MSUB a=1, b=1 → hi=0, lo=0xFFFFFFFF. Without the macro, both ops leave HI/LO unchanged and busy stays 0.
